div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
Multi-cycle sequencer for the CPU's HI/LO divide path, replacing the single-cycle combinational divide with a radix-2 restoring iteration of one quotient bit per clock. It accepts a divide request from the EX stage and raises busy so the pipeline stalls. It owns the architectural HI/LO registers, including the direct HI/LO writes (mthi/mtlo), and it aborts cleanly on a pipeline flush.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  divide request; sampled only in IDLE or DONE
is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
dividend  input  WIDTH  operand a; sampled with start
divisor  input  WIDTH  operand b; sampled with start
cancel  input  1  pipeline flush; aborts an in-flight divide
hi_we  input  1  direct write of wdata into HI (mthi)
lo_we  input  1  direct write of wdata into LO (mtlo)
wdata  input  WIDTH  data for direct HI/LO writes
busy  output  1  high while a divide is in flight; drives the pipeline stall
done  output  1  one-cycle pulse in the cycle the new HI/LO values are first visible
hi  output  WIDTH  HI register: remainder
lo  output  WIDTH  LO register: quotient

Behaviour:
- Reset: the synchronous rst acts on the clock edge. It forces state=IDLE, busy=0, done=0, hi=0, lo=0, and clears all internal registers. rst mid-operation discards the divide. rst has priority over every other input.
- FSM states: IDLE, PREP, ITER, FIX, DONE.
  - IDLE: if start, latch operands and is_signed, then go to PREP. Otherwise stay.
  - PREP (1 cycle): form magnitudes. If signed and the operand MSB is 1, use the two's-complement negation; otherwise use the raw value. Record neg_q = sign(a) XOR sign(b) and neg_r = sign(a), both forced to 0 when unsigned. Record div_zero = (divisor == 0). Clear the partial remainder and the iteration counter. Go to ITER.
  - ITER (exactly WIDTH cycles): shift {rem, quo} left by 1 and bring in the next dividend bit. If rem >= |b|, subtract |b| and set the quotient LSB. The counter increments each cycle. Leave for FIX after the WIDTH-th iteration.
  - FIX (1 cycle): apply the sign rules and write HI/LO at the end of this cycle, then go to DONE.
    - lo = neg_q ? -quo : quo.
    - hi = neg_r ? -rem : rem.
    - Divide-by-zero overrides the sign rules: lo = all ones, hi = original dividend, regardless of is_signed.
  - DONE (1 cycle): done=1. If start, accept the new request (back-to-back) and go to PREP; otherwise go to IDLE.
- Latency: with start in cycle 0, busy is high in cycles 1..WIDTH+2 (1..34 for the default). done is high in cycle WIDTH+3 (35), with hi/lo already updated. busy=0 in IDLE and DONE.
- start while busy is ignored: operands are not re-sampled and the result is unaffected.
- Signed results match truncating division: the quotient rounds toward zero and the remainder takes the sign of the dividend.
  - Overflow case INT_MIN / -1: lo=0x80000000, hi=0. This falls out naturally from WIDTH-bit wrap; no special handling is needed.
- cancel:
  - In PREP, ITER or FIX: next state is IDLE, hi/lo are unchanged and no done pulse is produced.
  - cancel in the same cycle as an accepted start: the start is dropped.
  - cancel has lower priority than rst.
- Direct writes:
  - hi_we/lo_we update hi/lo at the clock edge only when busy=0 (IDLE or DONE). While busy they are dropped.
  - In FIX the divide result wins; FIX is a busy cycle, so direct writes are dropped there anyway.
  - hi_we and lo_we may both be asserted; both registers then get wdata.
- Outputs are registered; there is no combinational path from inputs to hi/lo/done. busy decodes the state register only.

Test Plan:
- Unsigned: start, is_signed=0, a=100, b=7 in cycle 0 -> busy cycles 1..34, done in cycle 35, lo=14, hi=2.
- Signed, mixed signs: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Unsigned with the same operands -> lo=0x7FFFFFFC, hi=1.
- Overflow and zero divisor:
  - Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - a=0x12345678, b=0, each signedness -> lo=0xFFFFFFFF, hi=0x12345678, latency still 35.
- Abort: start a divide, cancel in cycle 10 -> IDLE in cycle 11, busy=0, no done pulse, hi/lo keep prior values. Repeat with rst in cycle 10 -> hi=lo=0.
- Back-to-back and ignored start: start 100/7, re-assert start with 9/4 during cycles 5..20 (ignored), then start 9/4 in the DONE cycle 35 -> second done in cycle 70 with lo=2, hi=1.
- Direct writes: in IDLE, hi_we=1 with wdata=0xDEADBEEF -> hi=0xDEADBEEF next cycle. lo_we pulsed while busy -> lo unaffected, final lo equals the quotient.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle HI/LO divide sequencer.
// Radix-2 restoring divide, one quotient bit per clock. The block owns the
// architectural HI/LO registers (divide results and mthi/mtlo writes) and
// abandons an in-flight divide on a pipeline flush.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [2:0]       state;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic             sgn;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic             accept;

    // Operand magnitudes, one restoring step, and the sign-corrected results.
    always_comb begin
        a_mag_c   = (sgn && a_raw[WIDTH-1]) ? (-a_raw) : a_raw;
        b_mag_c   = (sgn && b_raw[WIDTH-1]) ? (-b_raw) : b_raw;
        rem_shift = {rem, quo[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, b_mag});
        rem_diff  = rem_shift[WIDTH-1:0] - b_mag;
        fix_lo    = div_zero ? {WIDTH{1'b1}} : (neg_q ? (-quo) : quo);
        fix_hi    = div_zero ? a_raw         : (neg_r ? (-rem) : rem);
        accept    = start && !cancel;
    end

    // Sequencer state and divide datapath; a flush drops back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_raw    <= '0;
            b_raw    <= '0;
            sgn      <= 1'b0;
            b_mag    <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a_raw <= dividend;
                        b_raw <= divisor;
                        sgn   <= is_signed;
                        state <= ST_PREP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        quo      <= a_mag_c;
                        b_mag    <= b_mag_c;
                        neg_q    <= sgn & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                        neg_r    <= sgn & a_raw[WIDTH-1];
                        div_zero <= (b_raw == '0);
                        rem      <= '0;
                        cnt      <= '0;
                        state    <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        rem <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], rem_ge};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state <= cancel ? ST_IDLE : ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // HI/LO: divide result lands at the end of FIX; mthi/mtlo only when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == ST_FIX) begin
            if (!cancel) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end else if (!busy) begin
            if (hi_we) begin
                hi_q <= wdata;
            end
            if (lo_we) begin
                lo_q <= wdata;
            end
        end
    end

    // Status decodes straight from the state register.
    always_comb begin
        busy = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
        done = (state == ST_DONE);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed self-checking bench for div_seq_ctrl.
// Cycle k is the interval after the k-th rising edge following a request;
// inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_div_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        next_cycle();
        start     = 1'b0;
    endtask

    // Called in cycle 1; returns the cycle number in which done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            next_cycle();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        vectors++;
        if (hi !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_hi: got %h, expected 00000000", hi); end
        vectors++;
        if (lo !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_lo: got %h, expected 00000000", lo); end
    endtask

    task automatic test_unsigned;
        logic exp_busy;
        logic exp_done;
        dividend  = 32'd100;
        divisor   = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            next_cycle();
            start    = 1'b0;
            exp_busy = (k <= 34);
            exp_done = (k == 35);
            vectors++;
            if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL unsigned_busy_c%0d: got %b, expected %b", k, busy, exp_busy); end
            vectors++;
            if (done !== exp_done) begin miscompares++; $display("[TB] FAIL unsigned_done_c%0d: got %b, expected %b", k, done, exp_done); end
            if (k == 35) begin
                vectors++;
                if (lo !== 32'd14) begin miscompares++; $display("[TB] FAIL unsigned_lo: got %h, expected %h", lo, 32'd14); end
                vectors++;
                if (hi !== 32'd2) begin miscompares++; $display("[TB] FAIL unsigned_hi: got %h, expected %h", hi, 32'd2); end
            end
        end
    endtask

    task automatic test_signed;
        int lat;
        issue(32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done(lat);
        vectors++;
        if (lat != 35) begin miscompares++; $display("[TB] FAIL signed_latency: got %0d, expected 35", lat); end
        vectors++;
        if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("[TB] FAIL signed_lo: got %h, expected FFFFFFFD", lo); end
        vectors++;
        if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL signed_hi: got %h, expected FFFFFFFF", hi); end
        next_cycle();
        issue(32'hFFFFFFF9, 32'd2, 1'b0);
        wait_done(lat);
        vectors++;
        if (lo !== 32'h7FFFFFFC) begin miscompares++; $display("[TB] FAIL unsigned_same_lo: got %h, expected 7FFFFFFC", lo); end
        vectors++;
        if (hi !== 32'h00000001) begin miscompares++; $display("[TB] FAIL unsigned_same_hi: got %h, expected 00000001", hi); end
        next_cycle();
    endtask

    task automatic test_overflow_zero;
        int lat;
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done(lat);
        vectors++;
        if (lo !== 32'h80000000) begin miscompares++; $display("[TB] FAIL overflow_lo: got %h, expected 80000000", lo); end
        vectors++;
        if (hi !== 32'h0) begin miscompares++; $display("[TB] FAIL overflow_hi: got %h, expected 00000000", hi); end
        next_cycle();
        for (int s = 0; s < 2; s++) begin
            issue(32'h12345678, 32'h0, s[0]);
            wait_done(lat);
            vectors++;
            if (lat != 35) begin miscompares++; $display("[TB] FAIL divzero_latency_s%0d: got %0d, expected 35", s, lat); end
            vectors++;
            if (lo !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL divzero_lo_s%0d: got %h, expected FFFFFFFF", s, lo); end
            vectors++;
            if (hi !== 32'h12345678) begin miscompares++; $display("[TB] FAIL divzero_hi_s%0d: got %h, expected 12345678", s, hi); end
            next_cycle();
        end
    endtask

    task automatic test_direct_write;
        int lat;
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        next_cycle();
        hi_we = 1'b0;
        vectors++;
        if (hi !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL mthi_idle: got %h, expected DEADBEEF", hi); end
        lo_we = 1'b1;
        wdata = 32'hCAFEF00D;
        next_cycle();
        lo_we = 1'b0;
        vectors++;
        if (lo !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL mtlo_idle: got %h, expected CAFEF00D", lo); end
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h55AA55AA;
        next_cycle();
        hi_we = 1'b0;
        lo_we = 1'b0;
        vectors++;
        if (hi !== 32'h55AA55AA || lo !== 32'h55AA55AA) begin
            miscompares++; $display("[TB] FAIL both_we: got hi=%h lo=%h, expected 55AA55AA", hi, lo);
        end
        issue(32'd100, 32'd7, 1'b0);
        for (int k = 2; k <= 35; k++) begin
            next_cycle();
            lo_we = (k == 3 || k == 20 || k == 34);
            wdata = 32'h11111111;
        end
        lat = 0;
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_we_done: got %b, expected 1", done); end
        vectors++;
        if (lo !== 32'd14) begin miscompares++; $display("[TB] FAIL busy_we_lo: got %h, expected %h", lo, 32'd14); end
        vectors++;
        if (hi !== 32'd2) begin miscompares++; $display("[TB] FAIL busy_we_hi: got %h, expected %h", hi, 32'd2); end
        hi_we = 1'b1;
        wdata = 32'h0BADF00D;
        next_cycle();
        hi_we = 1'b0;
        vectors++;
        if (hi !== 32'h0BADF00D) begin miscompares++; $display("[TB] FAIL mthi_in_done: got %h, expected 0BADF00D", hi); end
    endtask

    task automatic test_cancel;
        int lat;
        logic seen;
        issue(32'd100, 32'd7, 1'b0);
        wait_done(lat);
        next_cycle();
        dividend = 32'd5;
        divisor  = 32'd1;
        start    = 1'b1;
        cancel   = 1'b1;
        next_cycle();
        start    = 1'b0;
        cancel   = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL start_cancel_busy: got %b, expected 0", busy); end
        issue(32'd9, 32'd4, 1'b0);
        for (int k = 2; k <= 10; k++) next_cycle();
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL cancel_busy_c10: got %b, expected 1", busy); end
        cancel = 1'b1;
        next_cycle();
        cancel = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_busy_c11: got %b, expected 0", busy); end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            next_cycle();
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_quiet: got activity=%b, expected 0", seen); end
        vectors++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            miscompares++; $display("[TB] FAIL cancel_hilo: got hi=%h lo=%h, expected hi=00000002 lo=0000000e", hi, lo);
        end
    endtask

    task automatic test_reset_abort;
        logic seen;
        issue(32'd9, 32'd4, 1'b0);
        for (int k = 2; k <= 10; k++) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rst_abort_status: got busy=%b done=%b, expected 0 0", busy, done);
        end
        vectors++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++; $display("[TB] FAIL rst_abort_hilo: got hi=%h lo=%h, expected 0 0", hi, lo);
        end
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            next_cycle();
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_abort_quiet: got activity=%b, expected 0", seen); end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(32'd100, 32'd7, 1'b0);
        for (int k = 2; k <= 35; k++) begin
            next_cycle();
            if (k >= 5 && k <= 20) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd4;
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_done: got %b, expected 1", done); end
        vectors++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            miscompares++; $display("[TB] FAIL b2b_first_result: got hi=%h lo=%h, expected hi=00000002 lo=0000000e", hi, lo);
        end
        issue(32'd9, 32'd4, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy_c36: got %b, expected 1", busy); end
        wait_done(lat);
        vectors++;
        if (35 + lat != 70) begin miscompares++; $display("[TB] FAIL b2b_second_done_cycle: got %0d, expected 70", 35 + lat); end
        vectors++;
        if (lo !== 32'd2 || hi !== 32'd1) begin
            miscompares++; $display("[TB] FAIL b2b_second_result: got hi=%h lo=%h, expected hi=00000001 lo=00000002", hi, lo);
        end
        next_cycle();
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'h0;
        divisor   = 32'h0;
        cancel    = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = 32'h0;
        $display("[TB] div_seq_ctrl directed tests start");
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow_zero();
        test_direct_write();
        test_cancel();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
